// File: rtl/countdown_pkg.sv
// Shared types and step classifier for the countdown monitor.
// COUNTDOWN_MONITOR_HOLD_EN makes a repeated value a legal hold step.
package countdown_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StLocked,
    StFault
  } state_e;

  typedef enum logic [1:0] {
    StepLegal,
    StepReload,
    StepBad,
    StepHold
  } step_e;

  // Values are zero-extended to 32 bits; n is the real bus width (1..31).
  function automatic step_e classify_step(input logic [31:0] prev, input logic [31:0] cur,
                                          input int unsigned n);
    logic [63:0] mask;
    logic [31:0] max_val;
    logic [31:0] exp_val;
    mask    = (64'd1 << n) - 64'd1;
    max_val = mask[31:0];
    exp_val = (prev - 32'd1) & max_val;
    if (cur == exp_val) begin
      return StepLegal;
    end
`ifdef COUNTDOWN_MONITOR_HOLD_EN
    if (cur == prev) begin
      return StepHold;
    end
`endif
    // For n=1 this also catches 1 -> 1, which is deliberately a reload.
    if ((cur == max_val) && (prev != 32'd0)) begin
      return StepReload;
    end
    return StepBad;
  endfunction

endpackage

// File: rtl/countdown_sat_counter.sv
// Saturating up-counter used for the wrap and fault event counts.
module countdown_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/countdown_monitor.sv
// Locks onto a free-running countdown bus and reports wraps, reloads and faults.
// Define COUNTDOWN_MONITOR_HOLD_EN to accept repeated values as hold steps.
module countdown_monitor
  import countdown_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [N-1:0]     i_count_in,
  input  logic             i_sample_en,
  output logic             o_locked,
  output logic             o_terminal,
  output logic             o_reload,
  output logic             o_error,
  output logic [CNT_W-1:0] o_wrap_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int unsigned GOOD_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  state_e              r_state, w_state_next;
  logic [N-1:0]        r_prev;
  logic [GOOD_W-1:0]   r_good, w_good_next, w_good_inc;
  logic                r_terminal, w_terminal_next;
  logic                r_reload, w_reload_next;
  logic                r_error, w_error_next;
  logic                w_wrap_inc, w_err_inc;
  step_e               w_step;

  assign w_step     = classify_step(32'(r_prev), 32'(i_count_in), N);
  assign w_good_inc = r_good + GOOD_W'(1);

  always_comb begin
    w_state_next    = r_state;
    w_good_next     = r_good;
    w_terminal_next = 1'b0;
    w_reload_next   = 1'b0;
    w_error_next    = r_error;
    w_wrap_inc      = 1'b0;
    w_err_inc       = 1'b0;
    if (i_sample_en) begin
      unique case (r_state)
        StIdle: begin
          w_state_next = StAcquire;
          w_good_next  = '0;
        end
        StAcquire, StFault: begin
          unique case (w_step)
            StepLegal: begin
              w_good_next = w_good_inc;
              if (w_good_inc >= GOOD_W'(LOCK_CNT)) begin
                w_state_next = StLocked;
              end
            end
            StepHold:   ;
            StepReload: w_good_next = '0;
            StepBad: begin
              w_good_next = '0;
              // Faults only count once the sequence has been trusted.
              if (r_state == StFault) begin
                w_err_inc = 1'b1;
              end
            end
            default:    ;
          endcase
        end
        StLocked: begin
          unique case (w_step)
            StepLegal: begin
              if (r_prev == '0) begin
                w_terminal_next = 1'b1;
                w_wrap_inc      = 1'b1;
              end
            end
            StepHold:   ;
            StepReload: w_reload_next = 1'b1;
            StepBad: begin
              w_state_next = StFault;
              w_error_next = 1'b1;
              w_err_inc    = 1'b1;
              w_good_next  = '0;
            end
            default:    ;
          endcase
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_prev     <= '0;
      r_good     <= '0;
      r_terminal <= 1'b0;
      r_reload   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_good     <= w_good_next;
      r_terminal <= w_terminal_next;
      r_reload   <= w_reload_next;
      r_error    <= w_error_next;
      if (i_sample_en) begin
        r_prev <= i_count_in;
      end
    end
  end

  countdown_sat_counter #(
    .W (CNT_W)
  ) u_wrap_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_wrap_inc),
    .i_clr     (1'b0),
    .o_q       (o_wrap_count)
  );

  countdown_sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_err_inc),
    .i_clr     (1'b0),
    .o_q       (o_err_count)
  );

  assign o_locked   = (r_state == StLocked);
  assign o_terminal = r_terminal;
  assign o_reload   = r_reload;
  assign o_error    = r_error;

endmodule

// File: tb/tb_countdown_monitor.sv
// Directed bench: a default monitor and a CNT_W=2 monitor watch the same bus.
module tb_countdown_monitor;

  logic       clk;
  logic       rst_n;
  logic       sample_en;
  logic [3:0] count_in;

  logic       locked_a, term_a, rel_a, err_a;
  logic [7:0] wrap_a, errc_a;
  logic       locked_b, term_b, rel_b, err_b;
  logic [1:0] wrap_b, errc_b;

  int total;
  int bad;
  int exp_errc;

  countdown_monitor #(
    .N        (4),
    .CNT_W    (8),
    .LOCK_CNT (2)
  ) dut_a (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_count_in   (count_in),
    .i_sample_en  (sample_en),
    .o_locked     (locked_a),
    .o_terminal   (term_a),
    .o_reload     (rel_a),
    .o_error      (err_a),
    .o_wrap_count (wrap_a),
    .o_err_count  (errc_a)
  );

  countdown_monitor #(
    .N        (4),
    .CNT_W    (2),
    .LOCK_CNT (2)
  ) dut_b (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_count_in   (count_in),
    .i_sample_en  (sample_en),
    .o_locked     (locked_b),
    .o_terminal   (term_b),
    .o_reload     (rel_b),
    .o_error      (err_b),
    .o_wrap_count (wrap_b),
    .o_err_count  (errc_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int v);
    count_in  = 4'(v);
    sample_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".locked"}, 32'(locked_a), 0);
    check_eq({tag, ".terminal"}, 32'(term_a), 0);
    check_eq({tag, ".reload"}, 32'(rel_a), 0);
    check_eq({tag, ".error"}, 32'(err_a), 0);
    check_eq({tag, ".wrap"}, 32'(wrap_a), 0);
    check_eq({tag, ".errc"}, 32'(errc_a), 0);
    check_eq({tag, ".errc_b"}, 32'(errc_b), 0);
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    sample_en = 1'b0;
    count_in  = 4'd0;
    total     = 0;
    bad       = 0;

    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Acquire on 15,14,13.
    step(15);
    check_eq("acq1.locked", 32'(locked_a), 0);
    step(14);
    check_eq("acq2.locked", 32'(locked_a), 0);
    step(13);
    check_eq("acq3.locked", 32'(locked_a), 1);
    check_eq("acq3.error", 32'(err_a), 0);
    check_eq("acq3.wrap", 32'(wrap_a), 0);

    // Terminal wrap 0 -> 15.
    for (int v = 12; v >= 1; v--) step(v);
    step(0);
    check_eq("at0.terminal", 32'(term_a), 0);
    step(15);
    check_eq("wrap.terminal", 32'(term_a), 1);
    check_eq("wrap.count", 32'(wrap_a), 1);
    check_eq("wrap.locked", 32'(locked_a), 1);
    step(14);
    check_eq("wrap_after.terminal", 32'(term_a), 0);
    check_eq("wrap_after.count", 32'(wrap_a), 1);
    check_eq("wrap_after.error", 32'(err_a), 0);

    // Reload from 9, then a fault, then relock.
    for (int v = 13; v >= 9; v--) step(v);
    step(15);
    check_eq("reload.pulse", 32'(rel_a), 1);
    check_eq("reload.locked", 32'(locked_a), 1);
    check_eq("reload.error", 32'(err_a), 0);
    check_eq("reload.terminal", 32'(term_a), 0);
    step(5);
    check_eq("fault.reload", 32'(rel_a), 0);
    check_eq("fault.locked", 32'(locked_a), 0);
    check_eq("fault.error", 32'(err_a), 1);
    check_eq("fault.errc", 32'(errc_a), 1);
    step(4);
    check_eq("relock1.locked", 32'(locked_a), 0);
    step(3);
    check_eq("relock2.locked", 32'(locked_a), 1);
    check_eq("relock2.errc", 32'(errc_a), 1);

    // Second wrap, then down to 7.
    for (int v = 2; v >= 0; v--) step(v);
    step(15);
    check_eq("wrap2.terminal", 32'(term_a), 1);
    check_eq("wrap2.count", 32'(wrap_a), 2);
    for (int v = 14; v >= 7; v--) step(v);
    check_eq("at7.locked", 32'(locked_a), 1);

    // Sample enable low: nothing moves.
    sample_en = 1'b0;
    count_in  = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle.locked", 32'(locked_a), 1);
      check_eq("idle.terminal", 32'(term_a), 0);
    end
    step(6);
    check_eq("resume.locked", 32'(locked_a), 1);
    check_eq("resume.errc", 32'(errc_a), 1);
    check_eq("resume.wrap", 32'(wrap_a), 2);

    // Asynchronous reset between edges.
    rst_n = 1'b0;
    #2;
    check_all_zero("midreset");
    rst_n = 1'b1;

    // Repeated value while locked.
    step(10);
    step(9);
    step(8);
    check_eq("rep.prelock", 32'(locked_a), 1);
    check_eq("rep.preerr", 32'(err_a), 0);
    step(8);
`ifdef COUNTDOWN_MONITOR_HOLD_EN
    check_eq("hold.error", 32'(err_a), 0);
    check_eq("hold.locked", 32'(locked_a), 1);
    exp_errc = 0;
`else
    check_eq("rep.error", 32'(err_a), 1);
    check_eq("rep.locked", 32'(locked_a), 0);
    exp_errc = 1;
`endif
    check_eq("rep.errc", 32'(errc_a), 32'(exp_errc));

    // Five bad steps: wide counter counts, narrow one saturates at 3.
    step(3);
    step(10);
    step(3);
    step(10);
    step(3);
    exp_errc = exp_errc + 5;
    check_eq("sat.errc_a", 32'(errc_a), 32'(exp_errc));
    check_eq("sat.errc_b", 32'(errc_b), 3);
    check_eq("sat.error", 32'(err_a), 1);
    check_eq("sat.locked", 32'(locked_a), 0);
    check_eq("sat.wrap_b", 32'(wrap_b), 0);
    step(10);
    check_eq("sat2.errc_a", 32'(errc_a), 32'(exp_errc + 1));
    check_eq("sat2.errc_b", 32'(errc_b), 3);

    // Reset mid-run, then confirm a full reacquire from IDLE.
    rst_n = 1'b0;
    #2;
    check_all_zero("endreset");
    rst_n = 1'b1;
    step(7);
    check_eq("reacq1.locked", 32'(locked_a), 0);
    step(6);
    check_eq("reacq2.locked", 32'(locked_a), 0);
    step(5);
    check_eq("reacq3.locked", 32'(locked_a), 1);
    check_eq("reacq3.error", 32'(err_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
